// File: rtl/mem_arbiter_if.sv
// Bundle of IF-stage, MEM-stage and SRAM pin signals around the memory arbiter.
// slave = arbiter view, master = requesters + SRAM view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              IfReq;
  logic [ADDR_W-1:0] IfAddr;
  logic [DATA_W-1:0] IfData;
  logic              IfValid;
  logic              Flush;
  logic              PcPause;

  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              MemDone;

  logic [ADDR_W-1:0] Ram_Addr;
  logic [DATA_W-1:0] Ram_DataOut;
  logic              Ram_DataOe;
  logic [DATA_W-1:0] Ram_DataIn;
  logic              Ram_Ce_n;
  logic              Ram_Oe_n;
  logic              Ram_We_n;

  modport slave (
    input  IfReq, IfAddr, Flush, MemReq, MemWe, MemAddr, MemWData, Ram_DataIn,
    output IfData, IfValid, PcPause, MemRData, MemDone,
           Ram_Addr, Ram_DataOut, Ram_DataOe, Ram_Ce_n, Ram_Oe_n, Ram_We_n
  );

  modport master (
    output IfReq, IfAddr, Flush, MemReq, MemWe, MemAddr, MemWData, Ram_DataIn,
    input  IfData, IfValid, PcPause, MemRData, MemDone,
           Ram_Addr, Ram_DataOut, Ram_DataOe, Ram_Ce_n, Ram_Oe_n, Ram_We_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter for fetch and load/store; alternates grants when both wait.
// Reads: Valid/Done one cycle after WAIT_CYCLES+1 strobe cycles; writes add a RECOVER cycle.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic      Clk,
  input logic      Rst,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_IF   = 3'd1;
  localparam logic [2:0] ST_RD_MEM  = 3'd2;
  localparam logic [2:0] ST_WR_MEM  = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  localparam logic LG_IF  = 1'b0;
  localparam logic LG_MEM = 1'b1;

  logic [2:0]        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              flush_q,      flush_d;
  logic              if_valid_q,   if_valid_d;
  logic              mem_done_q,   mem_done_d;
  logic [DATA_W-1:0] if_data_q,    if_data_d;
  logic [DATA_W-1:0] mem_rdata_q,  mem_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
  logic [DATA_W-1:0] ram_dout_q,   ram_dout_d;
  logic              ram_doe_q,    ram_doe_d;
  logic              ram_ce_n_q,   ram_ce_n_d;
  logic              ram_oe_n_q,   ram_oe_n_d;
  logic              ram_we_n_q,   ram_we_n_d;

  logic if_elig;
  logic mem_elig;
  logic grant_if;
  logic grant_mem;
  logic last_cnt;
  logic flush_seen;

  // A requester whose completion pulse is visible this cycle is not re-granted.
  assign if_elig    = bus.IfReq & ~if_valid_q & ~bus.Flush;
  assign mem_elig   = bus.MemReq & ~mem_done_q;
  assign grant_if   = if_elig & (~mem_elig | (last_grant_q == LG_MEM));
  assign grant_mem  = mem_elig & ~grant_if;
  assign last_cnt   = (cnt_q == CNT_LAST);
  assign flush_seen = flush_q | bus.Flush;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    flush_d      = flush_q;
    if_valid_d   = 1'b0;
    mem_done_d   = 1'b0;
    if_data_d    = if_data_q;
    mem_rdata_d  = mem_rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_dout_d   = ram_dout_q;
    ram_doe_d    = ram_doe_q;
    ram_ce_n_d   = ram_ce_n_q;
    ram_oe_n_d   = ram_oe_n_q;
    ram_we_n_d   = ram_we_n_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        flush_d = 1'b0;
        if (grant_if) begin
          state_d      = ST_RD_IF;
          last_grant_d = LG_IF;
          ram_addr_d   = bus.IfAddr;
          ram_ce_n_d   = 1'b0;
          ram_oe_n_d   = 1'b0;
        end else if (grant_mem) begin
          last_grant_d = LG_MEM;
          ram_addr_d   = bus.MemAddr;
          ram_ce_n_d   = 1'b0;
          if (bus.MemWe) begin
            state_d    = ST_WR_MEM;
            ram_we_n_d = 1'b0;
            ram_doe_d  = 1'b1;
            ram_dout_d = bus.MemWData;
          end else begin
            state_d    = ST_RD_MEM;
            ram_oe_n_d = 1'b0;
          end
        end
      end

      // A flushed fetch still runs its full strobe so the SRAM never sees a truncated cycle.
      ST_RD_IF: begin
        flush_d = flush_seen;
        if (last_cnt) begin
          state_d    = ST_IDLE;
          if_data_d  = bus.Ram_DataIn;
          if_valid_d = ~flush_seen;
          ram_ce_n_d = 1'b1;
          ram_oe_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_MEM: begin
        if (last_cnt) begin
          state_d     = ST_IDLE;
          mem_rdata_d = bus.Ram_DataIn;
          mem_done_d  = 1'b1;
          ram_ce_n_d  = 1'b1;
          ram_oe_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Data bus stays driven through RECOVER to give the SRAM hold time after We_n rises.
      ST_WR_MEM: begin
        if (last_cnt) begin
          state_d    = ST_RECOVER;
          mem_done_d = 1'b1;
          ram_ce_n_d = 1'b1;
          ram_we_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RECOVER: begin
        state_d   = ST_IDLE;
        ram_doe_d = 1'b0;
      end

      default: begin
        state_d    = ST_IDLE;
        ram_ce_n_d = 1'b1;
        ram_oe_n_d = 1'b1;
        ram_we_n_d = 1'b1;
        ram_doe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= LG_MEM;
      flush_q      <= 1'b0;
      if_valid_q   <= 1'b0;
      mem_done_q   <= 1'b0;
      if_data_q    <= '0;
      mem_rdata_q  <= '0;
      ram_addr_q   <= '0;
      ram_dout_q   <= '0;
      ram_doe_q    <= 1'b0;
      ram_ce_n_q   <= 1'b1;
      ram_oe_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      flush_q      <= flush_d;
      if_valid_q   <= if_valid_d;
      mem_done_q   <= mem_done_d;
      if_data_q    <= if_data_d;
      mem_rdata_q  <= mem_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_dout_q   <= ram_dout_d;
      ram_doe_q    <= ram_doe_d;
      ram_ce_n_q   <= ram_ce_n_d;
      ram_oe_n_q   <= ram_oe_n_d;
      ram_we_n_q   <= ram_we_n_d;
    end
  end

  assign bus.IfData      = if_data_q;
  assign bus.IfValid     = if_valid_q;
  assign bus.MemRData    = mem_rdata_q;
  assign bus.MemDone     = mem_done_q;
  assign bus.Ram_Addr    = ram_addr_q;
  assign bus.Ram_DataOut = ram_dout_q;
  assign bus.Ram_DataOe  = ram_doe_q;
  assign bus.Ram_Ce_n    = ram_ce_n_q;
  assign bus.Ram_Oe_n    = ram_oe_n_q;
  assign bus.Ram_We_n    = ram_we_n_q;
  assign bus.PcPause     = bus.IfReq & ~if_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios on WAIT_CYCLES=1 and 0 instances,
// plus randomized fetch/load/store traffic checked against a reference memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (.Clk(clk), .Rst(rst), .bus(bus1));
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (.Clk(clk), .Rst(rst), .bus(bus0));

  // SRAM contents: a distinct pattern per address until a word is written
  logic [15:0] sram   [0:65535];
  bit          sram_w [0:65535];
  logic [15:0] ref_d  [0:65535];
  bit          ref_w  [0:65535];
  bit          force_en = 1'b0;
  logic [15:0] force_val = 16'h0000;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a * 16'h0007) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_w[a] ? ref_d[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    if (!bus1.Ram_Ce_n && !bus1.Ram_We_n && bus1.Ram_DataOe) begin
      sram[bus1.Ram_Addr]   = bus1.Ram_DataOut;
      sram_w[bus1.Ram_Addr] = 1'b1;
    end
    if (force_en) bus1.Ram_DataIn = force_val;
    else bus1.Ram_DataIn = sram_w[bus1.Ram_Addr] ? sram[bus1.Ram_Addr] : init_word(bus1.Ram_Addr);
  end

  // Pin-level rules on the WAIT_CYCLES=1 instance, checked every cycle
  int oe_run = 0;
  int we_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      oe_run = 0;
      we_run = 0;
    end else begin
      checks++;
      if (bus1.PcPause !== (bus1.IfReq & ~bus1.IfValid)) begin
        errors++;
        $display("FAIL pc_pause t=%0t got %b exp %b", $time, bus1.PcPause, bus1.IfReq & ~bus1.IfValid);
      end
      checks++;
      if (bus1.Ram_Ce_n !== (bus1.Ram_Oe_n & bus1.Ram_We_n)) begin
        errors++;
        $display("FAIL ce_coherence t=%0t ce_n %b oe_n %b we_n %b", $time, bus1.Ram_Ce_n, bus1.Ram_Oe_n, bus1.Ram_We_n);
      end
      if (!bus1.Ram_Oe_n) oe_run++;
      else begin
        if (oe_run != 0) begin
          checks++;
          if (oe_run != 2) begin errors++; $display("FAIL oe_width got %0d exp 2", oe_run); end
        end
        oe_run = 0;
      end
      if (!bus1.Ram_We_n) we_run++;
      else begin
        if (we_run != 0) begin
          checks++;
          if (we_run != 2) begin errors++; $display("FAIL we_width got %0d exp 2", we_run); end
        end
        we_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus1.IfReq = 0; bus1.IfAddr = 0; bus1.Flush = 0;
    bus1.MemReq = 0; bus1.MemWe = 0; bus1.MemAddr = 0; bus1.MemWData = 0;
    bus0.IfReq = 0; bus0.IfAddr = 0; bus0.Flush = 0;
    bus0.MemReq = 0; bus0.MemWe = 0; bus0.MemAddr = 0; bus0.MemWData = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    force_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({bus1.Ram_Ce_n, bus1.Ram_Oe_n, bus1.Ram_We_n, bus1.Ram_DataOe, bus1.IfValid, bus1.MemDone} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 111000",
               {bus1.Ram_Ce_n, bus1.Ram_Oe_n, bus1.Ram_We_n, bus1.Ram_DataOe, bus1.IfValid, bus1.MemDone});
    end
    checks++;
    if ({bus1.IfData, bus1.MemRData, bus1.Ram_Addr, bus1.Ram_DataOut} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {bus1.IfData, bus1.MemRData, bus1.Ram_Addr, bus1.Ram_DataOut});
    end
    checks++;
    if (bus1.PcPause !== 1'b0) begin errors++; $display("FAIL reset_pause got %b exp 0", bus1.PcPause); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic exp_oe_n, exp_v, exp_p;
    do_reset();
    force_en  = 1'b1;
    force_val = 16'h1234;
    bus1.IfReq  = 1'b1;
    bus1.IfAddr = 16'h0010;
    #1;
    checks++;
    if (bus1.PcPause !== 1'b1) begin errors++; $display("FAIL fetch_pause0 got %b exp 1", bus1.PcPause); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_oe_n = !(k == 1 || k == 2);
      exp_v    = (k == 3);
      exp_p    = (k < 3);
      checks++;
      if ({bus1.Ram_Oe_n, bus1.IfValid, bus1.PcPause} !== {exp_oe_n, exp_v, exp_p}) begin
        errors++;
        $display("FAIL fetch_cycle%0d oe_n/valid/pause got %b exp %b", k,
                 {bus1.Ram_Oe_n, bus1.IfValid, bus1.PcPause}, {exp_oe_n, exp_v, exp_p});
      end
      if (k <= 2) begin
        checks++;
        if (bus1.Ram_Addr !== 16'h0010) begin errors++; $display("FAIL fetch_addr got %h exp 0010", bus1.Ram_Addr); end
      end
      if (k == 3) begin
        checks++;
        if (bus1.IfData !== 16'h1234) begin errors++; $display("FAIL fetch_data got %h exp 1234", bus1.IfData); end
        bus1.IfReq = 1'b0;
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_write_priority();
    logic [5:0] exp;
    do_reset();
    bus1.IfReq = 1'b1; bus1.IfAddr = 16'h0010;
    bus1.MemReq = 1'b1; bus1.MemWe = 1'b1; bus1.MemAddr = 16'h8000; bus1.MemWData = 16'hBEEF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      // {Ce_n, Oe_n, We_n, DataOe, IfValid, MemDone}
      case (k)
        1, 2:    exp = 6'b001000;
        3:       exp = 6'b111010;
        4, 5:    exp = 6'b010100;
        6:       exp = 6'b111101;
        default: exp = 6'b111000;
      endcase
      checks++;
      if ({bus1.Ram_Ce_n, bus1.Ram_Oe_n, bus1.Ram_We_n, bus1.Ram_DataOe, bus1.IfValid, bus1.MemDone} !== exp) begin
        errors++;
        $display("FAIL prio_cycle%0d got %b exp %b", k,
                 {bus1.Ram_Ce_n, bus1.Ram_Oe_n, bus1.Ram_We_n, bus1.Ram_DataOe, bus1.IfValid, bus1.MemDone}, exp);
      end
      if (k == 3) begin
        checks++;
        if (bus1.IfData !== init_word(16'h0010)) begin
          errors++; $display("FAIL prio_ifdata got %h exp %h", bus1.IfData, init_word(16'h0010));
        end
        bus1.IfReq = 1'b0;
      end
      if (k >= 4 && k <= 6) begin
        checks++;
        if ({bus1.Ram_Addr, bus1.Ram_DataOut} !== {16'h8000, 16'hBEEF}) begin
          errors++; $display("FAIL prio_wr_bus cycle%0d got %h exp 8000beef", k, {bus1.Ram_Addr, bus1.Ram_DataOut});
        end
      end
      if (k == 6) bus1.MemReq = 1'b0;
    end
    checks++;
    if (!sram_w[16'h8000] || sram[16'h8000] !== 16'hBEEF) begin
      errors++; $display("FAIL prio_sram_word got %h exp beef", sram[16'h8000]);
    end
  endtask

  task automatic test_alternate();
    bit seq[$];
    do_reset();
    bus1.IfReq = 1'b1;  bus1.IfAddr = 16'h0020;
    bus1.MemReq = 1'b1; bus1.MemWe = 1'b0; bus1.MemAddr = 16'h0021;
    for (int c = 0; c < 200 && seq.size() < 8; c++) begin
      tick();
      if (bus1.IfValid) begin
        seq.push_back(1'b1);
        checks++;
        if (bus1.IfData !== init_word(16'h0020)) begin errors++; $display("FAIL alt_ifdata got %h exp %h", bus1.IfData, init_word(16'h0020)); end
      end
      if (bus1.MemDone) begin
        seq.push_back(1'b0);
        checks++;
        if (bus1.MemRData !== init_word(16'h0021)) begin errors++; $display("FAIL alt_memdata got %h exp %h", bus1.MemRData, init_word(16'h0021)); end
      end
    end
    checks++;
    if (seq.size() < 8) begin errors++; $display("FAIL alt_timeout got %0d completions exp 8", seq.size()); end
    foreach (seq[i]) begin
      checks++;
      if (seq[i] !== ((i % 2) == 0)) begin
        errors++; $display("FAIL alt_order idx %0d got %s exp %s", i, seq[i] ? "IF" : "MEM", ((i % 2) == 0) ? "IF" : "MEM");
      end
    end
    bus1.IfReq = 1'b0; bus1.MemReq = 1'b0;
    tick();
  endtask

  task automatic wait_oe_low(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = !bus1.Ram_Oe_n;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_timeout got no Oe_n exp Oe_n low", name); end
  endtask

  task automatic test_flush();
    bit saw_valid;
    bit got;
    do_reset();
    // flush in first strobe cycle
    bus1.IfReq = 1'b1; bus1.IfAddr = 16'h0030;
    wait_oe_low("flush_a");
    bus1.Flush = 1'b1; bus1.IfReq = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus1.Flush = 1'b0;
      saw_valid |= bus1.IfValid;
    end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL flush_early got IfValid 1 exp 0"); end
    // refetch must return the new address's data
    bus1.IfReq = 1'b1; bus1.IfAddr = 16'h0040;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (bus1.IfValid) begin
        got = 1'b1;
        checks++;
        if (bus1.IfData !== init_word(16'h0040)) begin errors++; $display("FAIL flush_refetch got %h exp %h", bus1.IfData, init_word(16'h0040)); end
        bus1.IfReq = 1'b0;
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL flush_refetch_timeout got 0 exp IfValid"); end
    tick();
    // flush in the final strobe cycle
    bus1.IfReq = 1'b1; bus1.IfAddr = 16'h0050;
    wait_oe_low("flush_b");
    tick();
    bus1.Flush = 1'b1; bus1.IfReq = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      bus1.Flush = 1'b0;
      saw_valid |= bus1.IfValid;
    end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL flush_late got IfValid 1 exp 0"); end
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    bit bad = 1'b0;
    do_reset();
    bus1.MemReq = 1'b1; bus1.MemWe = 1'b1; bus1.MemAddr = 16'h7000; bus1.MemWData = 16'h1111;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = !bus1.Ram_We_n;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstwr_timeout got no We_n exp We_n low"); end
    tick();
    rst = 1'b1;
    bus1.MemReq = 1'b0;
    tick();
    checks++;
    if ({bus1.Ram_Ce_n, bus1.Ram_We_n, bus1.Ram_DataOe, bus1.MemDone} !== 4'b1100) begin
      errors++;
      $display("FAIL rstwr_after got %b exp 1100", {bus1.Ram_Ce_n, bus1.Ram_We_n, bus1.Ram_DataOe, bus1.MemDone});
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      bad |= bus1.MemDone | ~bus1.Ram_We_n | bus1.Ram_DataOe;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstwr_quiet got activity exp none"); end
  endtask

  task automatic test_wait0();
    logic [3:0] exp;
    do_reset();
    bus0.Ram_DataIn = 16'hCAFE;
    bus0.MemReq = 1'b1; bus0.MemWe = 1'b0; bus0.MemAddr = 16'h0100;
    for (int k = 1; k <= 3; k++) begin
      tick();
      // {Ce_n, Oe_n, We_n, MemDone}
      exp = (k == 1) ? 4'b0010 : (k == 2) ? 4'b1111 : 4'b1110;
      checks++;
      if ({bus0.Ram_Ce_n, bus0.Ram_Oe_n, bus0.Ram_We_n, bus0.MemDone} !== exp) begin
        errors++;
        $display("FAIL w0_rd_cycle%0d got %b exp %b", k, {bus0.Ram_Ce_n, bus0.Ram_Oe_n, bus0.Ram_We_n, bus0.MemDone}, exp);
      end
      if (k == 1) begin
        checks++;
        if (bus0.Ram_Addr !== 16'h0100) begin errors++; $display("FAIL w0_addr got %h exp 0100", bus0.Ram_Addr); end
      end
      if (k == 2) begin
        checks++;
        if (bus0.MemRData !== 16'hCAFE) begin errors++; $display("FAIL w0_rdata got %h exp cafe", bus0.MemRData); end
        bus0.MemReq = 1'b0;
      end
    end
    bus0.MemReq = 1'b1; bus0.MemWe = 1'b1; bus0.MemAddr = 16'h0102; bus0.MemWData = 16'h5555;
    for (int k = 1; k <= 3; k++) begin
      tick();
      // {Ce_n, We_n, DataOe, MemDone}
      exp = (k == 1) ? 4'b0010 : (k == 2) ? 4'b1111 : 4'b1100;
      checks++;
      if ({bus0.Ram_Ce_n, bus0.Ram_We_n, bus0.Ram_DataOe, bus0.MemDone} !== exp) begin
        errors++;
        $display("FAIL w0_wr_cycle%0d got %b exp %b", k, {bus0.Ram_Ce_n, bus0.Ram_We_n, bus0.Ram_DataOe, bus0.MemDone}, exp);
      end
      if (k == 2) bus0.MemReq = 1'b0;
    end
  endtask

  task automatic if_client(input int n);
    logic [15:0] a;
    bit got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 16'($urandom_range(0, 31));
      bus1.IfAddr = a;
      bus1.IfReq  = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        tick();
        if (bus1.IfValid) begin
          got = 1'b1;
          checks++;
          if (bus1.IfData !== ref_rd(a)) begin errors++; $display("FAIL rnd_if addr %h got %h exp %h", a, bus1.IfData, ref_rd(a)); end
          bus1.IfReq = 1'b0;
        end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL rnd_if_timeout addr %h got no IfValid", a); bus1.IfReq = 1'b0; end
    end
  endtask

  task automatic mem_client(input int n);
    logic [15:0] a, d;
    bit we, got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      a  = 16'($urandom_range(0, 31));
      d  = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      bus1.MemAddr = a; bus1.MemWData = d; bus1.MemWe = we;
      bus1.MemReq  = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        tick();
        if (bus1.MemDone) begin
          got = 1'b1;
          if (we) begin
            ref_d[a] = d;
            ref_w[a] = 1'b1;
          end else begin
            checks++;
            if (bus1.MemRData !== ref_rd(a)) begin errors++; $display("FAIL rnd_mem addr %h got %h exp %h", a, bus1.MemRData, ref_rd(a)); end
          end
          bus1.MemReq = 1'b0;
        end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL rnd_mem_timeout addr %h got no MemDone", a); bus1.MemReq = 1'b0; end
    end
  endtask

  task automatic test_random();
    do_reset();
    fork
      if_client(40);
      mem_client(40);
    join
    // read back every touched word through the fetch port
    for (int i = 0; i < 32; i++) begin
      bit got = 1'b0;
      bus1.IfAddr = 16'(i);
      bus1.IfReq  = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        if (bus1.IfValid) begin
          got = 1'b1;
          checks++;
          if (bus1.IfData !== ref_rd(16'(i))) begin errors++; $display("FAIL rnd_readback addr %0d got %h exp %h", i, bus1.IfData, ref_rd(16'(i))); end
          bus1.IfReq = 1'b0;
        end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL rnd_readback_timeout addr %0d", i); bus1.IfReq = 1'b0; end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.Ram_DataIn = 16'h0000;
    clear_inputs();
    test_reset();
    test_fetch();
    test_write_priority();
    test_alternate();
    test_flush();
    test_reset_mid_write();
    test_wait0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
